// File: rtl/key_loader.sv
// Serial key loader: receives a parity-framed key over valid/ready, commits it to
// the locked core's key inputs, and locks out permanently after repeated bad frames.
module key_loader #(
   parameter int unsigned KEY_W    = 8,
   parameter int unsigned MAX_FAIL = 3
) (
   input  logic                            i_clk,
   input  logic                            i_rst_n,
   input  logic                            i_s_valid,
   output logic                            o_s_ready,
   input  logic                            i_s_bit,
   input  logic                            i_s_start,
   input  logic                            i_key_clear,
   output logic [KEY_W-1:0]                o_key_out,
   output logic                            o_key_valid,
   output logic                            o_done_ok,
   output logic                            o_done_err,
   output logic [$clog2(MAX_FAIL+1)-1:0]   o_fail_cnt,
   output logic                            o_locked_out
);

   localparam int unsigned FailW = $clog2(MAX_FAIL + 1);
   localparam int unsigned CntW  = $clog2(KEY_W + 1);
   localparam logic [CntW-1:0]  LastIdx = CntW'(KEY_W);
   localparam logic [FailW-1:0] FailMax = FailW'(MAX_FAIL);

   typedef enum logic [1:0] {StIdle, StShift, StCheck, StLockout} state_e;

   state_e           r_state, w_state_d;
   logic [CntW-1:0]  r_cnt, w_cnt_d;
   logic [KEY_W:0]   r_shift, w_shift_d;
   logic [KEY_W-1:0] r_key, w_key_d;
   logic             r_key_valid, w_key_valid_d;
   logic             r_done_ok, w_done_ok_d;
   logic             r_done_err, w_done_err_d;
   logic [FailW-1:0] r_fail, w_fail_d;
   logic             r_locked, w_locked_d;
   logic             w_ready;
   logic             w_xfer;
   logic [FailW-1:0] w_fail_inc;

   assign w_ready    = (r_state == StIdle) || (r_state == StShift);
   assign w_xfer     = i_s_valid && w_ready;
   assign w_fail_inc = r_fail + FailW'(1);

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state     <= StIdle;
         r_cnt       <= '0;
         r_shift     <= '0;
         r_key       <= '0;
         r_key_valid <= 1'b0;
         r_done_ok   <= 1'b0;
         r_done_err  <= 1'b0;
         r_fail      <= '0;
         r_locked    <= 1'b0;
      end else begin
         r_state     <= w_state_d;
         r_cnt       <= w_cnt_d;
         r_shift     <= w_shift_d;
         r_key       <= w_key_d;
         r_key_valid <= w_key_valid_d;
         r_done_ok   <= w_done_ok_d;
         r_done_err  <= w_done_err_d;
         r_fail      <= w_fail_d;
         r_locked    <= w_locked_d;
      end
   end

   always_comb begin
      w_state_d     = r_state;
      w_cnt_d       = r_cnt;
      w_shift_d     = r_shift;
      w_key_d       = r_key;
      w_key_valid_d = r_key_valid;
      w_done_ok_d   = 1'b0;
      w_done_err_d  = 1'b0;
      w_fail_d      = r_fail;
      w_locked_d    = r_locked;

      // Zeroise beats any frame activity, but lockout cannot be cleared by it.
      if (i_key_clear && (r_state != StLockout)) begin
         w_key_d       = '0;
         w_key_valid_d = 1'b0;
         w_state_d     = StIdle;
         w_cnt_d       = '0;
         w_shift_d     = '0;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (w_xfer && i_s_start) begin
                  w_shift_d = {{KEY_W{1'b0}}, i_s_bit};
                  w_cnt_d   = CntW'(1);
                  w_state_d = StShift;
               end
            end
            StShift: begin
               if (w_xfer) begin
                  if (i_s_start) begin
                     w_shift_d = {{KEY_W{1'b0}}, i_s_bit};
                     w_cnt_d   = CntW'(1);
                  end else begin
                     w_shift_d = {r_shift[KEY_W-1:0], i_s_bit};
                     if (r_cnt == LastIdx) begin
                        w_cnt_d   = '0;
                        w_state_d = StCheck;
                     end else begin
                        w_cnt_d = r_cnt + CntW'(1);
                     end
                  end
               end
            end
            StCheck: begin
               if (^r_shift == 1'b0) begin
                  w_key_d       = r_shift[KEY_W:1];
                  w_key_valid_d = 1'b1;
                  w_fail_d      = '0;
                  w_done_ok_d   = 1'b1;
                  w_state_d     = StIdle;
               end else begin
                  w_fail_d     = w_fail_inc;
                  w_done_err_d = 1'b1;
                  if (w_fail_inc == FailMax) begin
                     w_key_d       = '0;
                     w_key_valid_d = 1'b0;
                     w_locked_d    = 1'b1;
                     w_state_d     = StLockout;
                  end else begin
                     w_state_d = StIdle;
                  end
               end
            end
            StLockout: begin
               w_key_d       = '0;
               w_key_valid_d = 1'b0;
               w_locked_d    = 1'b1;
            end
            default: w_state_d = StIdle;
         endcase
      end
   end

   assign o_s_ready    = w_ready;
   assign o_key_out    = r_key;
   assign o_key_valid  = r_key_valid;
   assign o_done_ok    = r_done_ok;
   assign o_done_err   = r_done_err;
   assign o_fail_cnt   = r_fail;
   assign o_locked_out = r_locked;

endmodule

// File: tb/tb_key_loader.sv
// Directed plus randomized bench for key_loader against a frame-level reference model.
module tb_key_loader;

   localparam int unsigned KEY_W    = 8;
   localparam int unsigned MAX_FAIL = 3;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             s_valid, s_ready, s_bit, s_start, key_clear;
   logic [KEY_W-1:0] key_out;
   logic             key_valid, done_ok, done_err, locked_out;
   logic [1:0]       fail_cnt;

   int checks = 0;
   int errors = 0;

   // Reference model state, updated once per completed frame or control event.
   logic [KEY_W-1:0] m_key;
   logic             m_valid;
   int               m_fail;
   logic             m_locked;

   always #5 clk = ~clk;

   key_loader #(.KEY_W(KEY_W), .MAX_FAIL(MAX_FAIL)) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_s_valid   (s_valid),
      .o_s_ready   (s_ready),
      .i_s_bit     (s_bit),
      .i_s_start   (s_start),
      .i_key_clear (key_clear),
      .o_key_out   (key_out),
      .o_key_valid (key_valid),
      .o_done_ok   (done_ok),
      .o_done_err  (done_err),
      .o_fail_cnt  (fail_cnt),
      .o_locked_out(locked_out)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_model(input string tag);
      chk({tag, "_key"}, 32'(key_out), 32'(m_key));
      chk({tag, "_valid"}, 32'(key_valid), 32'(m_valid));
      chk({tag, "_fail"}, 32'(fail_cnt), 32'(m_fail));
      chk({tag, "_locked"}, 32'(locked_out), 32'(m_locked));
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      m_key = '0; m_valid = 1'b0; m_fail = 0; m_locked = 1'b0;
   endtask

   // Offers one bit and waits (bounded) until it is accepted.
   task automatic send_bit(input logic b, input logic st, input bit gaps);
      int n;
      if (gaps && ($urandom_range(0, 3) == 0)) tick();
      n = 0;
      while (!s_ready && n < 20) begin
         tick();
         n++;
      end
      if (n == 20) chk("ready_timeout", 32'(s_ready), 32'd1);
      s_valid = 1'b1; s_bit = b; s_start = st;
      tick();
      s_valid = 1'b0; s_bit = 1'b0; s_start = 1'b0;
   endtask

   task automatic send_partial(input logic [KEY_W-1:0] k, input int nbits, input logic st);
      for (int i = 0; i < nbits; i++) begin
         send_bit(k[KEY_W-1-i], (i == 0) ? st : 1'b0, 1'b0);
         chk("partial_no_ok", 32'(done_ok), 32'd0);
         chk("partial_no_err", 32'(done_err), 32'd0);
      end
   endtask

   // Sends a full frame and checks the CHECK-cycle stall, result pulses and model state.
   task automatic do_frame(input logic [KEY_W-1:0] k, input logic par, input bit gaps,
                           input string tag);
      bit good;
      for (int i = 0; i <= KEY_W; i++)
         send_bit((i < KEY_W) ? k[KEY_W-1-i] : par, i == 0, gaps);
      chk({tag, "_stall"}, 32'(s_ready), 32'd0);
      chk({tag, "_early_pulse"}, 32'({done_ok, done_err}), 32'd0);
      tick();
      good = ((^k) ^ par) == 1'b0;
      if (good) begin
         m_key = k; m_valid = 1'b1; m_fail = 0;
      end else begin
         m_fail++;
         if (m_fail == MAX_FAIL) begin
            m_locked = 1'b1; m_key = '0; m_valid = 1'b0;
         end
      end
      chk({tag, "_ok"}, 32'(done_ok), 32'(good));
      chk({tag, "_err"}, 32'(done_err), 32'(!good));
      chk({tag, "_ready"}, 32'(s_ready), 32'(!m_locked));
      chk_model(tag);
      tick();
      chk({tag, "_pulse_end"}, 32'({done_ok, done_err}), 32'd0);
   endtask

   initial begin
      logic [KEY_W-1:0] k;
      logic             p;
      rst_n = 1'b1; s_valid = 1'b0; s_bit = 1'b0; s_start = 1'b0; key_clear = 1'b0;
      m_key = '0; m_valid = 1'b0; m_fail = 0; m_locked = 1'b0;

      // Reset state
      tick();
      do_reset();
      chk_model("reset");
      chk("reset_pulses", 32'({done_ok, done_err}), 32'd0);
      chk("reset_ready", 32'(s_ready), 32'd1);

      // Good frame then bad parity then recovery
      do_frame(8'hA5, 1'b0, 1'b0, "good_a5");
      do_frame(8'h3C, 1'b1, 1'b0, "bad_3c");
      do_frame(8'h3C, 1'b0, 1'b0, "good_3c");

      // Resync mid-frame: earlier partial frame abandoned without error
      send_partial(8'hF0, 4, 1'b1);
      do_frame(8'h5A, 1'b0, 1'b0, "resync_5a");

      // Bits without s_start while idle are discarded
      send_partial(8'hFF, 3, 1'b0);
      repeat (3) tick();
      chk("idle_discard_ready", 32'(s_ready), 32'd1);
      chk_model("idle_discard");

      // key_clear mid-frame
      do_frame(8'hA5, 1'b0, 1'b0, "pre_clear");
      send_partial(8'hC3, 5, 1'b1);
      key_clear = 1'b1;
      tick();
      key_clear = 1'b0;
      m_key = '0; m_valid = 1'b0;
      chk_model("clear");
      chk("clear_pulses", 32'({done_ok, done_err}), 32'd0);
      chk("clear_ready", 32'(s_ready), 32'd1);
      for (int i = 5; i <= KEY_W; i++) begin
         send_bit(1'b1, 1'b0, 1'b0);
         chk("clear_discard_pulses", 32'({done_ok, done_err}), 32'd0);
      end
      repeat (2) tick();
      chk_model("clear_discard");

      // Randomized frames; a bad frame is avoided when it would trigger lockout
      for (int n = 0; n < 40; n++) begin
         k = KEY_W'($urandom);
         p = ^k;
         if ($urandom_range(0, 3) == 0 && m_fail < MAX_FAIL - 1) p = ~p;
         if ($urandom_range(0, 7) == 0) begin
            key_clear = 1'b1;
            tick();
            key_clear = 1'b0;
            m_key = '0; m_valid = 1'b0;
            chk_model("rnd_clear");
         end
         do_frame(k, p, 1'b1, "rnd");
      end

      // Lockout after three consecutive bad frames
      do_reset();
      do_frame(8'h11, 1'b1, 1'b0, "lock1");
      do_frame(8'h22, 1'b1, 1'b0, "lock2");
      do_frame(8'h33, 1'b1, 1'b0, "lock3");
      chk("lock_state", 32'(locked_out), 32'd1);
      s_valid = 1'b1; key_clear = 1'b1;
      for (int i = 0; i <= KEY_W; i++) begin
         s_bit = (i < KEY_W) ? 1'b0 : 1'b0;
         s_start = (i == 0);
         tick();
         chk("lock_ignore_pulses", 32'({done_ok, done_err}), 32'd0);
         chk("lock_ignore_ready", 32'(s_ready), 32'd0);
      end
      s_valid = 1'b0; s_start = 1'b0; key_clear = 1'b0;
      tick();
      chk_model("lock_hold");
      do_reset();
      chk_model("lock_reset");
      chk("lock_reset_ready", 32'(s_ready), 32'd1);

      // Reset mid-frame
      do_frame(8'hA5, 1'b0, 1'b0, "pre_rst");
      do_frame(8'h01, 1'b0, 1'b0, "pre_rst_bad");
      send_partial(8'h96, 6, 1'b1);
      do_reset();
      chk_model("mid_reset");
      chk("mid_reset_pulses", 32'({done_ok, done_err}), 32'd0);
      do_frame(8'hA5, 1'b0, 1'b0, "post_rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
